// File: rtl/ddr_region_loader.sv
// rtl/ddr_region_loader.sv - streams source words into up to NUM_REGION DDR regions, one lane per write
module ddr_region_loader #(
  parameter int                    PORT_DATAWIDTH = 128,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    NUM_REGION     = 5,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    TX_SIZE_WIDTH  = 20,
  parameter logic [ADDR_WIDTH-1:0] DDR_BASE       = 32'h0800_0000
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [NUM_REGION-1:0]                 cfg_en,
  input  logic [NUM_REGION*ADDR_WIDTH-1:0]      cfg_base,
  input  logic [NUM_REGION*TX_SIZE_WIDTH-1:0]   cfg_words,
  input  logic                                  s_valid,
  input  logic [PORT_DATAWIDTH-1:0]             s_data,
  output logic                                  s_ready,
  output logic                                  mem_we,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic                                  mem_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [$clog2(NUM_REGION+1)-1:0]       cur_region
);
  localparam int LANES = PORT_DATAWIDTH / DATA_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW    = $clog2(NUM_REGION + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [RW-1:0] NREG      = RW'(NUM_REGION);

  typedef enum logic [2:0] {IDLE, SETUP, FETCH, WRITE, DONE} state_t;

  state_t                              state_q, state_d;
  logic [RW-1:0]                       region_q, region_d;
  logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
  logic [TX_SIZE_WIDTH-1:0]            cnt_q, cnt_d;
  logic [LW-1:0]                       lane_q, lane_d;
  logic [PORT_DATAWIDTH-1:0]           word_q, word_d;
  logic [NUM_REGION-1:0]               en_q, en_d;
  logic [NUM_REGION*ADDR_WIDTH-1:0]    base_q, base_d;
  logic [NUM_REGION*TX_SIZE_WIDTH-1:0] words_q, words_d;
  logic                                err_q, err_d;

  // region_q reaches NUM_REGION in SETUP; clamp the select so it never indexes past the table
  logic [RW-1:0]            ridx;
  logic                     sel_en;
  logic [ADDR_WIDTH-1:0]    sel_base;
  logic [TX_SIZE_WIDTH-1:0] sel_words;

  always_comb begin
    ridx      = (region_q < NREG) ? region_q : '0;
    sel_en    = en_q[ridx];
    sel_base  = base_q[int'(ridx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_words = words_q[int'(ridx)*TX_SIZE_WIDTH +: TX_SIZE_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    word_d   = word_q;
    en_d     = en_q;
    base_d   = base_q;
    words_d  = words_q;
    err_d    = err_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            en_d     = cfg_en;
            base_d   = cfg_base;
            words_d  = cfg_words;
            err_d    = 1'b0;
            region_d = '0;
            cnt_d    = '0;
            lane_d   = '0;
            state_d  = SETUP;
          end
        end
        SETUP: begin
          if (region_q == NREG) begin
            state_d = DONE;
          end else if (!sel_en || sel_words == '0) begin
            region_d = region_q + 1'b1;
          end else if (sel_base < DDR_BASE) begin
            err_d    = 1'b1;
            region_d = region_q + 1'b1;
          end else begin
            addr_d  = sel_base - DDR_BASE;
            cnt_d   = '0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (s_valid) begin
            word_d  = s_data;
            lane_d  = '0;
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            addr_d = addr_q + 1'b1;
            if (lane_q == LAST_LANE) begin
              lane_d = '0;
              cnt_d  = cnt_q + 1'b1;
              if (cnt_q + 1'b1 == sel_words) begin
                region_d = region_q + 1'b1;
                state_d  = SETUP;
              end else begin
                state_d = FETCH;
              end
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      region_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      lane_q   <= '0;
      word_q   <= '0;
      en_q     <= '0;
      base_q   <= '0;
      words_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      en_q     <= en_d;
      base_q   <= base_d;
      words_q  <= words_d;
      err_q    <= err_d;
    end
  end

  assign s_ready    = (state_q == FETCH);
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign cur_region = region_q;
endmodule
